// File: rtl/mem_req_arbiter_pkg.sv
// Shared definitions for the memory request arbiter: command layout,
// requester IDs and the instruction-fetch command builder.
package mem_req_arbiter_pkg;

  localparam int MEM_CMD_SIZE = 71;
  localparam int CMD_WR       = 70;
  localparam int CMD_SIZE     = 68;  // [69:68]
  localparam int CMD_WSTRB    = 64;  // [67:64]
  localparam int CMD_ADDR     = 32;  // [63:32]
  localparam int CMD_WDATA    = 0;   // [31:0]

  localparam logic REQ_ID_INST = 1'b0;
  localparam logic REQ_ID_DATA = 1'b1;

  typedef logic [MEM_CMD_SIZE-1:0] mem_cmd_t;

  // Instruction fetches are always word reads with no write data.
  function automatic mem_cmd_t inst_cmd(input logic [31:0] addr);
    return {1'b0, 2'b10, 4'b0000, addr, 32'b0};
  endfunction

endpackage

// File: rtl/mem_req_arbiter_order_fifo.sv
// order_fifo: small synchronous FIFO with async active-low reset.
// A push is taken when not full, or when full and popping the same cycle.
module order_fifo #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4,
  parameter int PW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q;
  logic [PW-1:0]               head_q, head_d, tail_q, tail_d;
  logic [PW:0]                 cnt_q, cnt_d;
  logic                        do_push, do_pop;

  assign full_o  = (cnt_q == (PW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign dout_o  = mem_q[head_q];
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Next pointer/count; pointers wrap naturally since DEPTH is a power of 2.
  always_comb begin
    head_d = do_pop  ? head_q + PW'(1) : head_q;
    tail_d = do_push ? tail_q + PW'(1) : tail_q;
    cnt_d  = cnt_q;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + (PW+1)'(1);
      2'b01:   cnt_d = cnt_q - (PW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointer and occupancy state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage; entries are only read while occupied, so no reset needed.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[tail_q] <= din_i;
  end

endmodule

// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: shares one SRAM-like port between the IF and EX/ME
// requesters. Address phases are arbitrated combinationally, a stalled grant
// is locked until accepted, and an order FIFO routes in-order responses back.
// Optional: ARB_ROUND_ROBIN_EN alternates the winner on collisions instead of
// fixed data priority.
module mem_req_arbiter
  import mem_req_arbiter_pkg::*;
#(
  parameter int MAX_OUTST = 4,
  parameter int OID_W     = $clog2(MAX_OUTST)
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    inst_req,
  input  logic [31:0]             inst_addr,
  output logic                    inst_addr_ok,
  output logic                    inst_data_ok,
  output logic [31:0]             inst_rdata,
  input  logic                    data_req,
  input  logic [MEM_CMD_SIZE-1:0] data_cmd,
  output logic                    data_addr_ok,
  output logic                    data_data_ok,
  output logic [31:0]             data_rdata,
  output logic                    mem_req,
  output logic [MEM_CMD_SIZE-1:0] mem_cmd,
  input  logic                    mem_addr_ok,
  input  logic                    mem_data_ok,
  input  logic [31:0]             mem_rdata
);

  logic lock_vld_q, lock_vld_d, lock_id_q, lock_id_d;
  logic win_id, win_req, accept;
  logic fifo_full, fifo_empty, head_id;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_grant_q, last_grant_d;
`endif

  // Winner selection: a held lock wins, otherwise collision policy applies.
  always_comb begin
    win_id = REQ_ID_INST;
    if (lock_vld_q)
      win_id = lock_id_q;
    else if (data_req && inst_req)
`ifdef ARB_ROUND_ROBIN_EN
      win_id = (last_grant_q == REQ_ID_DATA) ? REQ_ID_INST : REQ_ID_DATA;
`else
      win_id = REQ_ID_DATA;
`endif
    else if (data_req)
      win_id = REQ_ID_DATA;
  end

  assign win_req      = (win_id == REQ_ID_DATA) ? data_req : inst_req;
  assign mem_req      = win_req && !fifo_full;
  assign mem_cmd      = (win_id == REQ_ID_DATA) ? data_cmd : inst_cmd(inst_addr);
  assign accept       = mem_req && mem_addr_ok;
  assign inst_addr_ok = accept && (win_id == REQ_ID_INST);
  assign data_addr_ok = accept && (win_id == REQ_ID_DATA);

  // Lock next-state: set while a presented request stalls, clear on accept;
  // held untouched while mem_req is gated off by a full FIFO.
  always_comb begin
    lock_vld_d = lock_vld_q;
    lock_id_d  = lock_id_q;
    if (mem_req) begin
      lock_vld_d = !mem_addr_ok;
      lock_id_d  = win_id;
    end
  end

  // Lock registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lock_vld_q <= 1'b0;
      lock_id_q  <= REQ_ID_INST;
    end else begin
      lock_vld_q <= lock_vld_d;
      lock_id_q  <= lock_id_d;
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  assign last_grant_d = accept ? win_id : last_grant_q;

  // Remember who was granted last so collisions alternate.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) last_grant_q <= REQ_ID_INST;
    else         last_grant_q <= last_grant_d;
  end
`endif

  order_fifo #(.WIDTH(1), .DEPTH(MAX_OUTST), .PW(OID_W)) u_order_fifo (
    .clk     (clk),
    .rst_n   (resetn),
    .push_i  (accept),
    .din_i   (win_id),
    .pop_i   (mem_data_ok),
    .dout_o  (head_id),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign inst_data_ok = mem_data_ok && !fifo_empty && (head_id == REQ_ID_INST);
  assign data_data_ok = mem_data_ok && !fifo_empty && (head_id == REQ_ID_DATA);
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;

`ifndef SYNTHESIS
  // A response with nothing outstanding points at a downstream protocol bug.
  always_ff @(posedge clk) begin
    if (resetn)
      assert (!(mem_data_ok && fifo_empty))
        else $warning("mem_req_arbiter: mem_data_ok with no outstanding request");
  end
`endif

endmodule
